// File: rtl/cntr8_ctrl_pkg.sv
// Shared encodings for the cntr8 command controller: command codes, FSM states
// and the default counter width.
package cntr8_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 3;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_LOAD = 2'b01,
      CMD_INC  = 2'b10,
      CMD_CLR  = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/cntr8_arb_ctrl_rr_arb2.sv
// Two-way combinational round-robin select; the priority pointer lives in the parent.
module rr_arb2
   import cntr8_ctrl_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic rr,
   output logic sel_valid,
   output logic sel_idx
);

   assign sel_valid = req0 | req1;
   // On contention the pointer decides; otherwise whoever is asking wins.
   assign sel_idx   = (req0 & req1) ? rr : req1;

endmodule

// File: rtl/cntr8_arb_ctrl.sv
// Command controller for the loadable cntr8 counter: arbitrates two requesters
// round-robin and sequences load/inc strobes one command at a time.
module cntr8_arb_ctrl
   import cntr8_ctrl_pkg::*;
#(
   parameter int   WIDTH   = DEFAULT_WIDTH,
   parameter logic RR_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic [1:0]       cmd0,
   input  logic [WIDTH-1:0] arg0,
   input  logic             req1,
   input  logic [1:0]       cmd1,
   input  logic [WIDTH-1:0] arg1,
   input  logic [WIDTH-1:0] cnt,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             load,
   output logic             inc,
   output logic [WIDTH-1:0] d_in,
   output logic             busy
);

   localparam logic [WIDTH:0]   REM_ONE  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   REM_FULL = REM_ONE << WIDTH;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   state_e           state_q, state_n;
   cmd_e             cmd_q, cmd_n;
   logic             rr_q, rr_n;
   logic             owner_q, owner_n;
   logic [WIDTH:0]   rem_q, rem_n;

   logic             sel_valid, sel_idx;
   cmd_e             sel_cmd;
   logic [WIDTH-1:0] sel_arg;

   logic             gnt0_n, gnt1_n, done0_n, done1_n;
   logic             load_n, inc_n, busy_n;
   logic [WIDTH-1:0] d_in_n, result_n;

   rr_arb2 u_arb (
      .req0      (req0),
      .req1      (req1),
      .rr        (rr_q),
      .sel_valid (sel_valid),
      .sel_idx   (sel_idx)
   );

   assign sel_cmd = sel_idx ? cmd_e'(cmd1) : cmd_e'(cmd0);
   assign sel_arg = sel_idx ? arg1 : arg0;

   always_comb begin
      state_n  = state_q;
      cmd_n    = cmd_q;
      rr_n     = rr_q;
      owner_n  = owner_q;
      rem_n    = rem_q;
      gnt0_n   = 1'b0;
      gnt1_n   = 1'b0;
      done0_n  = 1'b0;
      done1_n  = 1'b0;
      load_n   = 1'b0;
      inc_n    = 1'b0;
      d_in_n   = '0;
      result_n = '0;

      case (state_q)
         S_IDLE: begin
            if (sel_valid) begin
               state_n = S_EXEC;
               owner_n = sel_idx;
               cmd_n   = sel_cmd;
               gnt0_n  = ~sel_idx;
               gnt1_n  = sel_idx;
               case (sel_cmd)
                  CMD_LOAD: begin
                     load_n = 1'b1;
                     d_in_n = sel_arg;
                  end
                  CMD_CLR:  load_n = 1'b1;
                  CMD_INC: begin
                     inc_n = 1'b1;
                     rem_n = (sel_arg == '0) ? REM_FULL : {1'b0, sel_arg};
                  end
                  default: ;
               endcase
            end
         end
         S_EXEC: begin
            if (cmd_q == CMD_INC && rem_q > REM_ONE) begin
               inc_n = 1'b1;
               rem_n = rem_q - REM_ONE;
            end else begin
               state_n = S_DONE;
               rem_n   = '0;
               done0_n = ~owner_q;
               done1_n = owner_q;
               // The counter updates on the same edge, so report its next value.
               if (load)
                  result_n = d_in;
               else if (inc)
                  result_n = cnt + CNT_ONE;
               else
                  result_n = cnt;
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
            rr_n    = ~owner_q;
         end
         default: state_n = S_IDLE;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cmd_q   <= CMD_NOP;
         rr_q    <= RR_INIT;
         owner_q <= 1'b0;
         rem_q   <= '0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         load    <= 1'b0;
         inc     <= 1'b0;
         busy    <= 1'b0;
         d_in    <= '0;
         result  <= '0;
      end else begin
         state_q <= state_n;
         cmd_q   <= cmd_n;
         rr_q    <= rr_n;
         owner_q <= owner_n;
         rem_q   <= rem_n;
         gnt0    <= gnt0_n;
         gnt1    <= gnt1_n;
         done0   <= done0_n;
         done1   <= done1_n;
         load    <= load_n;
         inc     <= inc_n;
         busy    <= busy_n;
         d_in    <= d_in_n;
         result  <= result_n;
      end
   end

endmodule

// File: doc/cntr8_arb_ctrl.md
Name: cntr8_arb_ctrl

Overview:
- Command controller and 2-requester round-robin arbiter for the loadable 3-bit counter (cntr8).
- Accepts LOAD, CLEAR and burst-INC commands from two independent requesters.
- Sequences the counter's load/inc/d_in controls one command at a time.
- Returns a done pulse carrying the resulting counter value to the requester that issued the command.

Parameters:
- WIDTH, 3, counter width; d_in, arg and result width; burst length arg==0 means 2^WIDTH.
- RR_INIT, 0, requester index holding priority after reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 command request; level, held until gnt0
- cmd0  input  2  requester 0 command: 00 NOP, 01 LOAD, 10 INC burst, 11 CLEAR
- arg0  input  WIDTH  requester 0 load value or burst length
- req1, cmd1, arg1  input  1/2/WIDTH  same as above, requester 1
- cnt  input  WIDTH  current counter value, fed back from cntr8
- gnt0, gnt1  output  1  one-cycle grant pulse; cmd/arg captured on this cycle
- done0, done1  output  1  one-cycle completion pulse
- result  output  WIDTH  counter value, valid only while done0 or done1 = 1
- load  output  1  counter load strobe
- inc  output  1  counter increment strobe
- d_in  output  WIDTH  counter load data
- busy  output  1  high in EXEC and DONE

Behaviour:
- All outputs registered.
- Reset (async, any state): state=IDLE, rr pointer=RR_INIT, remaining=0; all outputs 0, including d_in and result.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Samples req0/req1 each cycle.
  - One request pending: select it.
  - Both pending: select the requester pointed to by rr.
  - Selection on cycle t -> cycle t+1: state=EXEC, gnt_sel=1 for exactly that cycle, cmd/arg latched internally.
- EXEC:
  - First EXEC cycle coincides with the gnt cycle.
  - LOAD: load=1, d_in=arg for 1 cycle.
  - CLEAR: load=1, d_in=0 for 1 cycle.
  - NOP: 1 cycle with load=inc=0.
  - INC: inc=1 for N consecutive cycles, N=arg, arg==0 -> N=2^WIDTH. remaining counter is WIDTH+1 bits.
  - Next state is DONE after the last EXEC cycle.
  - load and inc are never both 1.
- DONE (1 cycle):
  - load=inc=0; done_sel=1; result=cnt sampled at this edge, i.e. after the last counter update.
  - rr pointer flips to the non-served requester.
  - Next state IDLE.
- Latency, request first seen in IDLE at cycle t:
  - LOAD/CLEAR/NOP: gnt at t+1, done at t+2.
  - INC N: inc high t+1..t+N, done at t+N+1.
- Handshake rules:
  - Requester holds req/cmd/arg stable until it sees gnt.
  - A req still high when the FSM is back in IDLE is treated as a new command; back-to-back commands from one requester are legal.
  - Minimum spacing between grants: 3 cycles for single-cycle commands.
- Fairness: with both requesters asserting continuously, grants strictly alternate.
- Changes to the non-selected requester's req/cmd/arg during EXEC/DONE have no effect.
- Counter wrap-around (7 -> 0) is the counter's behaviour; the controller does not detect or flag it.
- Reset asserted mid-burst: inc drops immediately (async), and no done is issued for the aborted command.

Decomposition:
- Shared package/include cntr8_ctrl_pkg holds:
  - Command encodings CMD_NOP/LOAD/INC/CLR.
  - FSM state encodings S_IDLE/S_EXEC/S_DONE.
  - Default WIDTH.
- One sub-module, rr_arb2:
  - 2-way combinational round-robin select from req0, req1 and the rr pointer.
  - Outputs sel_valid and sel_idx.
  - Pointer register stays in the parent and updates in DONE.

Test Plan:
- Reset then req0=1, cmd0=LOAD, arg0=5 -> gnt0 and load=1, d_in=5 at t+1; done0=1, result=5 at t+2; busy high for 2 cycles.
- Counter at 6, req1 INC arg1=3 -> inc high for exactly 3 cycles; done1 with result=1 (wrap 6->7->0->1); gnt0/done0 never asserted.
- req0 and req1 both held high from reset, cmd=CLEAR/LOAD 2 -> grants alternate gnt0, gnt1, gnt0, ...; each done matches the preceding grant index.
- INC with arg=0 -> inc high for 8 cycles; result equals the starting cnt.
- Assert reset during the 4th inc cycle of an arg=6 burst -> inc/busy drop at once, no done pulse; after release, a new req0 LOAD 3 completes normally with result=3.
- NOP from req1 -> gnt1 then done1 one cycle later; load=inc=0 throughout; result=current cnt unchanged.
